// File: rtl/pattern_loader.sv
// Sequencer for the serial pattern buffer shift chain: loads host bytes into
// the chain MSB first, or rotates the chain so every byte can be read back
// without disturbing its contents.
module pattern_loader #(
    parameter int unsigned BUF_BYTES = 27,
    parameter int unsigned BYTE_W    = 8
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              cmd_load,
    input  logic              cmd_read,
    input  logic              abort,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              ssel,
    output logic              sin,
    input  logic              sout
);

    localparam int unsigned BIT_CNT_W  = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam int unsigned BYTE_CNT_W = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(BYTE_W - 1);
    localparam logic [BYTE_CNT_W-1:0] BYTE_LAST = BYTE_CNT_W'(BUF_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LFETCH,
        LSHIFT,
        RSHIFT,
        RHOLD,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [BYTE_W-1:0]     sreg;
    logic [BYTE_W-1:0]     cap;
    logic                  last_bit;
    logic                  last_byte;
    logic                  shift_on;

    assign last_bit  = (bit_cnt == BIT_LAST);
    assign last_byte = (byte_cnt == BYTE_LAST);
    assign rd_data   = cap;

    // State register
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nx = state;
        wr_ready = 1'b0;
        rd_valid = 1'b0;
        done     = 1'b0;
        shift_on = 1'b0;
        sin      = 1'b0;
        busy     = (state != IDLE);

        case (state)
            IDLE: begin
                if (cmd_load) begin
                    state_nx = LFETCH;
                end else if (cmd_read) begin
                    state_nx = RSHIFT;
                end
            end
            LFETCH: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    state_nx = LSHIFT;
                end
            end
            LSHIFT: begin
                shift_on = 1'b1;
                sin      = sreg[BYTE_W-1];
                if (last_bit) begin
                    state_nx = last_byte ? DONE : LFETCH;
                end
            end
            RSHIFT: begin
                shift_on = 1'b1;
                sin      = sout;
                if (last_bit) begin
                    state_nx = RHOLD;
                end
            end
            RHOLD: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    state_nx = last_byte ? DONE : RSHIFT;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (abort && (state != IDLE)) begin
            state_nx = IDLE;
        end

        // Reset gates the shift so a reset edge never moves the buffer
        ssel = shift_on & rst_n;
        sin  = sin & rst_n;
    end

    // Bit/byte counters and the load/capture shift registers
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sreg     <= '0;
            cap      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                end
                LFETCH: begin
                    bit_cnt <= '0;
                    if (wr_valid) begin
                        sreg <= wr_data;
                    end
                end
                LSHIFT: begin
                    sreg    <= {sreg[BYTE_W-2:0], 1'b0};
                    bit_cnt <= last_bit ? '0 : bit_cnt + BIT_CNT_W'(1);
                    if (last_bit && !last_byte) begin
                        byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                    end
                end
                RSHIFT: begin
                    cap     <= {cap[BYTE_W-2:0], sout};
                    bit_cnt <= last_bit ? '0 : bit_cnt + BIT_CNT_W'(1);
                end
                RHOLD: begin
                    bit_cnt <= '0;
                    if (rd_ready && !last_byte) begin
                        byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                    end
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule
